// File: rtl/gmm_intr_pkg.sv
// Shared constants for the gmm interrupt controller: register offsets,
// AXI response encoding, source limit and the register decoder.
package gmm_intr_pkg;

  localparam int unsigned MAX_INTR = 32;

  localparam logic [31:0] OFF_GIE  = 32'h00;
  localparam logic [31:0] OFF_IER  = 32'h04;
  localparam logic [31:0] OFF_ISR  = 32'h08;
  localparam logic [31:0] OFF_IAR  = 32'h0C;
  localparam logic [31:0] OFF_IPR  = 32'h10;
  localparam logic [31:0] OFF_ISNS = 32'h14;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_GIE,
    SEL_IER,
    SEL_ISR,
    SEL_IAR,
    SEL_IPR,
    SEL_ISNS
  } reg_sel_e;

  // Byte-lane bits of the address are ignored; registers are word aligned.
  function automatic reg_sel_e decode(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr & ~32'h3)
      OFF_GIE:  sel = SEL_GIE;
      OFF_IER:  sel = SEL_IER;
      OFF_ISR:  sel = SEL_ISR;
      OFF_IAR:  sel = SEL_IAR;
      OFF_IPR:  sel = SEL_IPR;
      OFF_ISNS: sel = SEL_ISNS;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gmm_intr_detect.sv
// Per-source interrupt capture with sticky status and write-1 acknowledge.
// Edge sensing exists only when GMM_INTR_EDGE_DETECT_EN is defined.
module gmm_intr_detect
  import gmm_intr_pkg::*;
#(
  parameter int unsigned NUM_INTR = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_INTR-1:0] src,
  input  logic [NUM_INTR-1:0] edge_sel,
  input  logic [NUM_INTR-1:0] ack,
  output logic [NUM_INTR-1:0] status
);

  logic [NUM_INTR-1:0] set;

`ifdef GMM_INTR_EDGE_DETECT_EN
  logic [NUM_INTR-1:0] prev;

  // History clears to 0 so a source already high at reset release is an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= src;
  end

  assign set = src & (~edge_sel | ~prev);
`else
  logic [NUM_INTR-1:0] unused_edge_sel;
  assign unused_edge_sel = edge_sel;
  assign set = src;
`endif

  // A set in the acknowledge cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status <= '0;
    else        status <= (status & ~ack) | set;
  end

endmodule

// File: rtl/gmm_intr_ctrl.sv
// AXI4-Lite interrupt controller for the gmm core (GIE/IER/ISR/IAR/IPR/ISNS).
// Define GMM_INTR_EDGE_DETECT_EN to make ISNS writable and enable edge sources.
module gmm_intr_ctrl
  import gmm_intr_pkg::*;
#(
  parameter int unsigned NUM_INTR           = 4,
  parameter int unsigned IRQ_ACTIVE_HIGH    = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          s_axi_intr_aclk,
  input  logic                          s_axi_intr_aresetn,
  input  logic [NUM_INTR-1:0]           intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_intr_awaddr,
  input  logic [2:0]                    s_axi_intr_awprot,
  input  logic                          s_axi_intr_awvalid,
  output logic                          s_axi_intr_awready,
  input  logic [31:0]                   s_axi_intr_wdata,
  input  logic [3:0]                    s_axi_intr_wstrb,
  input  logic                          s_axi_intr_wvalid,
  output logic                          s_axi_intr_wready,
  output logic [1:0]                    s_axi_intr_bresp,
  output logic                          s_axi_intr_bvalid,
  input  logic                          s_axi_intr_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_intr_araddr,
  input  logic [2:0]                    s_axi_intr_arprot,
  input  logic                          s_axi_intr_arvalid,
  output logic                          s_axi_intr_arready,
  output logic [31:0]                   s_axi_intr_rdata,
  output logic [1:0]                    s_axi_intr_rresp,
  output logic                          s_axi_intr_rvalid,
  input  logic                          s_axi_intr_rready,
  output logic                          irq
);

  logic                          alive;
  logic                          aw_held, w_held, bvalid, rvalid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]                   wdata, wmask, wbits, rdata, rmux;
  logic [3:0]                    wstrb;
  logic                          wr_go, gie, irq_q;
  logic [NUM_INTR-1:0]           ier, isns, isr, ipr, ack;
  reg_sel_e                      wsel;
  logic                          unused_ok;

  // alive keeps every READY low while reset is held and for the edge after.
  assign s_axi_intr_awready = alive & ~aw_held & ~bvalid;
  assign s_axi_intr_wready  = alive & ~w_held & ~bvalid;
  assign s_axi_intr_arready = alive & ~rvalid;
  assign s_axi_intr_bvalid  = bvalid;
  assign s_axi_intr_bresp   = RESP_OKAY;
  assign s_axi_intr_rvalid  = rvalid;
  assign s_axi_intr_rdata   = rdata;
  assign s_axi_intr_rresp   = RESP_OKAY;

  assign wr_go = aw_held & w_held;
  assign ipr   = isr & ier;
  assign irq   = (IRQ_ACTIVE_HIGH != 0) ? irq_q : ~irq_q;

  always_comb begin
    wsel  = decode(32'(aw_addr));
    wmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    wbits = wdata & wmask;
    ack   = (wr_go && wsel == SEL_IAR) ? wbits[NUM_INTR-1:0] : '0;
  end

  always_comb begin
    rmux = '0;
    case (decode(32'(s_axi_intr_araddr)))
      SEL_GIE:  rmux[0]            = gie;
      SEL_IER:  rmux[NUM_INTR-1:0] = ier;
      SEL_ISR:  rmux[NUM_INTR-1:0] = isr;
      SEL_IPR:  rmux[NUM_INTR-1:0] = ipr;
      SEL_ISNS: rmux[NUM_INTR-1:0] = isns;
      default:  rmux               = '0;
    endcase
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      alive   <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      alive <= 1'b1;
      if (s_axi_intr_awvalid && s_axi_intr_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_intr_awaddr;
      end
      if (s_axi_intr_wvalid && s_axi_intr_wready) begin
        w_held <= 1'b1;
        wdata  <= s_axi_intr_wdata;
        wstrb  <= s_axi_intr_wstrb;
      end
      if (wr_go) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
      end else if (bvalid && s_axi_intr_bready) begin
        bvalid <= 1'b0;
      end
      // rdata samples registers before any same-edge write lands.
      if (s_axi_intr_arvalid && s_axi_intr_arready) begin
        rvalid <= 1'b1;
        rdata  <= rmux;
      end else if (rvalid && s_axi_intr_rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      gie   <= 1'b0;
      ier   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_go && wsel == SEL_GIE) gie <= (gie & ~wmask[0]) | wbits[0];
      if (wr_go && wsel == SEL_IER) ier <= (ier & ~wmask[NUM_INTR-1:0]) | wbits[NUM_INTR-1:0];
      irq_q <= gie & (|ipr);
    end
  end

`ifdef GMM_INTR_EDGE_DETECT_EN
  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) isns <= '0;
    else if (wr_go && wsel == SEL_ISNS) isns <= (isns & ~wmask[NUM_INTR-1:0]) | wbits[NUM_INTR-1:0];
  end
`else
  assign isns = '0;
`endif

  gmm_intr_detect #(.NUM_INTR(NUM_INTR)) u_detect (
    .clk      (s_axi_intr_aclk),
    .rst_n    (s_axi_intr_aresetn),
    .src      (intr_src),
    .edge_sel (isns),
    .ack      (ack),
    .status   (isr)
  );

  assign unused_ok = ^{s_axi_intr_awprot, s_axi_intr_arprot, wbits, wmask};

endmodule

// File: tb/tb_gmm_intr_ctrl.sv
// Self-checking bench for gmm_intr_ctrl: AXI-Lite register access, level/edge
// capture, acknowledge, strobes, back-pressure and reset abandonment.
module tb_gmm_intr_ctrl;

  localparam logic [4:0] A_GIE  = 5'h00;
  localparam logic [4:0] A_IER  = 5'h04;
  localparam logic [4:0] A_ISR  = 5'h08;
  localparam logic [4:0] A_IAR  = 5'h0C;
  localparam logic [4:0] A_IPR  = 5'h10;
  localparam logic [4:0] A_ISNS = 5'h14;
`ifdef GMM_INTR_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk, rst_n;
  logic [3:0]  intr_src;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    string       name;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [1:0] b_q[$];
  int         checks_total = 0;
  int         checks_passed = 0;

  gmm_intr_ctrl #(.NUM_INTR(4), .IRQ_ACTIVE_HIGH(1), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .s_axi_intr_aclk    (clk),
    .s_axi_intr_aresetn (rst_n),
    .intr_src           (intr_src),
    .s_axi_intr_awaddr  (awaddr),
    .s_axi_intr_awprot  (3'b000),
    .s_axi_intr_awvalid (awvalid),
    .s_axi_intr_awready (awready),
    .s_axi_intr_wdata   (wdata),
    .s_axi_intr_wstrb   (wstrb),
    .s_axi_intr_wvalid  (wvalid),
    .s_axi_intr_wready  (wready),
    .s_axi_intr_bresp   (bresp),
    .s_axi_intr_bvalid  (bvalid),
    .s_axi_intr_bready  (bready),
    .s_axi_intr_araddr  (araddr),
    .s_axi_intr_arprot  (3'b000),
    .s_axi_intr_arvalid (arvalid),
    .s_axi_intr_arready (arready),
    .s_axi_intr_rdata   (rdata),
    .s_axi_intr_rresp   (rresp),
    .s_axi_intr_rvalid  (rvalid),
    .s_axi_intr_rready  (rready),
    .irq                (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int unsigned w_lead, input int unsigned b_hold, input string nm);
    bit aw_done, w_done, aw_hs, w_hs;
    int unsigned k;
    logic [1:0] exp_resp;
    b_q.push_back(2'b00);
    aw_done = 1'b0; w_done = 1'b0; k = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = (w_lead == 0);
    while (!(aw_done && w_done) && k < 50) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      k++;
      if (!w_done && k >= w_lead) wvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks_total++;
    if (!(aw_done && w_done))
      $display("FAIL %s handshake aw_done=%0b w_done=%0b required=1/1", nm, aw_done, w_done);
    else checks_passed++;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (bvalid === 1'b1) break;
      k++;
    end
    exp_resp = b_q.pop_front();
    checks_total++;
    if (bvalid !== 1'b1) $display("FAIL %s bvalid timeout actual=%b required=1", nm, bvalid);
    else if (bresp !== exp_resp) $display("FAIL %s bresp actual=%b required=%b", nm, bresp, exp_resp);
    else checks_passed++;
    if (b_hold > 0) begin
      repeat (b_hold) @(negedge clk);
      checks_total++;
      if (bvalid !== 1'b1) $display("FAIL %s bvalid_hold actual=%b required=1", nm, bvalid);
      else checks_passed++;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string nm);
    rd_exp_t e;
    bit hs;
    int unsigned k;
    e.data = exp; e.resp = 2'b00; e.name = nm;
    rd_q.push_back(e);
    araddr = addr; arvalid = 1'b1; hs = 1'b0; k = 0;
    while (!hs && k < 20) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      k++;
    end
    arvalid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (rvalid === 1'b1) break;
      k++;
    end
    e = rd_q.pop_front();
    checks_total++;
    if (rvalid !== 1'b1) $display("FAIL %s rvalid timeout actual=%b required=1", e.name, rvalid);
    else if (rdata !== e.data) $display("FAIL %s rdata actual=%08h required=%08h", e.name, rdata, e.data);
    else checks_passed++;
    checks_total++;
    if (rresp !== e.resp) $display("FAIL %s rresp actual=%b required=%b", e.name, rresp, e.resp);
    else checks_passed++;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] offs [6];
    offs = '{A_GIE, A_IER, A_ISR, A_IAR, A_IPR, A_ISNS};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
      $display("FAIL reset_handshake actual=%05b required=00000", {awready, wready, arready, bvalid, rvalid});
    else checks_passed++;
    checks_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq actual=%b required=0", irq);
    else checks_passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 6; i++) axi_read(offs[i], 32'h0, $sformatf("reset_reg_%0h", offs[i]));
    checks_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq_after actual=%b required=0", irq);
    else checks_passed++;
  endtask

  task automatic test_level_irq();
    axi_write(A_GIE, 32'h1, 4'hF, 0, 0, "wr_gie");
    axi_write(A_IER, 32'h1, 4'hF, 0, 0, "wr_ier");
    intr_src = 4'b0001;
    @(posedge clk); #1;
    intr_src = 4'b0000;
    checks_total++;
    if (irq !== 1'b0) $display("FAIL level_irq_early actual=%b required=0", irq);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (irq !== 1'b1) $display("FAIL level_irq_2cyc actual=%b required=1", irq);
    else checks_passed++;
    axi_read(A_IPR, 32'h1, "level_ipr");
    axi_read(A_ISR, 32'h1, "level_isr_sticky");
  endtask

  task automatic test_ack();
    axi_write(A_IAR, 32'h1, 4'hF, 0, 0, "ack_low");
    checks_total++;
    if (irq !== 1'b0) $display("FAIL ack_irq_clear actual=%b required=0", irq);
    else checks_passed++;
    axi_read(A_IPR, 32'h0, "ack_ipr");
    axi_read(A_IAR, 32'h0, "iar_reads_zero");
    intr_src = 4'b0001;
    @(posedge clk); #1;
    axi_write(A_IAR, 32'h1, 4'hF, 0, 0, "ack_high");
    axi_read(A_ISR, 32'h1, "ack_set_wins");
    checks_total++;
    if (irq !== 1'b1) $display("FAIL ack_high_irq actual=%b required=1", irq);
    else checks_passed++;
    intr_src = 4'b0000;
    axi_write(A_IAR, 32'h1, 4'hF, 0, 0, "ack_final");
    axi_read(A_ISR, 32'h0, "ack_isr_clear");
  endtask

  task automatic test_edge();
    axi_write(A_ISNS, 32'h2, 4'hF, 0, 0, "wr_isns");
    axi_read(A_ISNS, EDGE ? 32'h2 : 32'h0, "isns_read");
    intr_src = 4'b0010;
    repeat (10) @(posedge clk);
    #1;
    axi_read(A_ISR, 32'h2, "edge_isr_set");
    axi_write(A_IAR, 32'h2, 4'hF, 0, 0, "edge_ack");
    axi_read(A_ISR, EDGE ? 32'h0 : 32'h2, "edge_isr_after_ack");
    intr_src = 4'b0000;
    axi_write(A_IAR, 32'h2, 4'hF, 0, 0, "edge_ack2");
    axi_read(A_ISR, 32'h0, "edge_isr_final");
    axi_write(A_ISNS, 32'h0, 4'hF, 0, 0, "clr_isns");
  endtask

  task automatic test_wstrb_delay();
    axi_write(A_IER, 32'h5, 4'h0, 0, 0, "strb_none");
    axi_read(A_IER, 32'h1, "strb_none_ier");
    axi_write(A_IER, 32'h0000_0A05, 4'h1, 3, 5, "strb_b0_late_w");
    axi_read(A_IER, 32'h5, "strb_b0_ier");
    axi_write(A_IER, 32'h0000_0A00, 4'h2, 0, 0, "strb_b1");
    axi_read(A_IER, 32'h5, "strb_b1_ier");
  endtask

  task automatic test_back_to_back();
    fork
      axi_write(A_IER, 32'h3, 4'hF, 0, 0, "simul_wr");
      axi_read(A_IER, 32'h5, "simul_rd_pre");
    join
    axi_read(A_IER, 32'h3, "simul_rd_post");
    axi_write(A_ISR, 32'hF, 4'hF, 0, 0, "wr_readonly");
    axi_read(A_ISR, 32'h0, "readonly_isr");
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr_unmapped");
    axi_read(5'h18, 32'h0, "unmapped_rd");
    axi_read(A_IER, 32'h3, "ier_unchanged");
  endtask

  task automatic test_reset_mid_read();
    int unsigned k;
    araddr = A_IER; arvalid = 1'b1; k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (arready === 1'b1) break;
      k++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    checks_total++;
    if (rvalid !== 1'b1) $display("FAIL midread_rvalid_pending actual=%b required=1", rvalid);
    else checks_passed++;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (rvalid !== 1'b0) $display("FAIL midread_rvalid_drop actual=%b required=0", rvalid);
    else checks_passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(A_IER, 32'h0, "post_reset_ier");
    axi_read(A_GIE, 32'h0, "post_reset_gie");
  endtask

  initial begin
    rst_n = 1'b0; intr_src = '0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_level_irq();
    test_ack();
    test_edge();
    test_wstrb_delay();
    test_back_to_back();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", checks_passed, checks_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gmm_intr_ctrl.md
GMM_INTR_CTRL -- requirements
Module: gmm_intr_ctrl

Interface
REQ-001 Parameter NUM_INTR, default 4, SHALL set the number of interrupt source inputs (1..32).
REQ-002 Parameter IRQ_ACTIVE_HIGH, default 1, SHALL select irq polarity (1 = active high, 0 = active low).
REQ-003 Parameter C_S_AXI_ADDR_WIDTH, default 5, SHALL set the AXI4-Lite address width; data width is fixed at 32.
REQ-004 s_axi_intr_aclk  in  1  sole clock.
REQ-005 s_axi_intr_aresetn  in  1  asynchronous active-low reset.
REQ-006 intr_src  in  NUM_INTR  interrupt requests from the gmm core, synchronous to s_axi_intr_aclk.
REQ-007 s_axi_intr_aw*/w*/b*/ar*/r*  AXI4-Lite slave channels (AWADDR, AWPROT, AWVALID/AWREADY, WDATA, WSTRB, WVALID/WREADY, BRESP, BVALID/BREADY, ARADDR, ARPROT, ARVALID/ARREADY, RDATA, RRESP, RVALID/RREADY).
REQ-008 irq  out  1  aggregated interrupt, polarity per IRQ_ACTIVE_HIGH.

Function
REQ-009 Register map: 0x00 GIE (bit0), 0x04 IER, 0x08 ISR (read-only status), 0x0C IAR (write-1-to-clear, reads 0), 0x10 IPR = ISR & IER (read-only), 0x14 ISNS (1 = edge, 0 = level).
REQ-010 Only bits [NUM_INTR-1:0] of IER/ISR/IAR/IPR/ISNS SHALL be implemented; upper bits read 0.
REQ-011 Write path SHALL accept AW and W independently, latch each, and perform the write in the cycle after both are held; AWREADY/WREADY deassert while a write is pending or BVALID is high.
REQ-012 BVALID SHALL assert the cycle after the register update and hold until BREADY; BRESP = OKAY always.
REQ-013 WSTRB SHALL be honoured per byte; writes to read-only/unmapped offsets are discarded with OKAY.
REQ-014 Read path: ARREADY high when no read is outstanding; RVALID asserts the cycle after the AR handshake and holds until RREADY; RRESP = OKAY; unmapped offsets return 0.
REQ-015 Level source i: ISR[i] SHALL set in the cycle after intr_src[i] is sampled high.
REQ-016 Edge source i: ISR[i] SHALL set in the cycle after a 0->1 transition of intr_src[i] (previous-sample register).
REQ-017 ISR[i] SHALL be sticky until a write of 1 to IAR[i]; a set condition in the same cycle as the acknowledge SHALL win (ISR[i] stays 1).
REQ-018 IER does not gate ISR capture; disabled sources still record status.
REQ-019 irq SHALL be registered: active exactly when GIE[0] & |IPR, one cycle after the contributing register changes.
REQ-020 Simultaneous read and write SHALL both complete; a read in the write-update cycle returns the pre-write value.

Reset
REQ-021 Asserting s_axi_intr_aresetn SHALL immediately clear GIE, IER, ISR, ISNS, edge history, all pending AXI state; AWREADY/WREADY/ARREADY/BVALID/RVALID = 0; irq inactive.
REQ-022 Reset mid-transaction SHALL abandon it with no response; first handshake after deassertion starts cleanly.
REQ-023 Edge history SHALL reset to 0, so a source already high at reset release counts as an edge.

Configuration
REQ-024 Macro GMM_INTR_EDGE_DETECT_EN defined: ISNS writable, edge detection per REQ-016.
REQ-025 Macro GMM_INTR_EDGE_DETECT_EN undefined: all sources level-sensitive, ISNS reads 0 and ignores writes, no edge-history flops.

Structure
REQ-026 Package gmm_intr_pkg SHALL hold register offset constants (GIE/IER/ISR/IAR/IPR/ISNS), OKAY response encoding, and max source count.
REQ-027 One sub-module gmm_intr_detect SHALL implement per-source level/edge capture and sticky ISR with ack; AXI-Lite decode stays in the top.

Verification
REQ-028 Reset, then read 0x00..0x14 -> all 0x00000000, irq inactive, RRESP OKAY.
REQ-029 Write GIE=0x1, IER=0x1, pulse intr_src[0] one cycle (level) -> irq active 2 cycles later; read IPR -> 0x00000001.
REQ-030 With intr_src low, write IAR=0x1 -> IPR reads 0x0, irq inactive 1 cycle after write; hold intr_src[0] high during ack -> ISR[0] stays 1.
REQ-031 ISNS=0x2, hold intr_src[1] high 10 cycles -> ISR=0x2 once; ack -> ISR=0x0 while input still high; build without GIE edge macro -> ISR re-sets to 0x2.
REQ-032 Write with AWVALID 3 cycles before WVALID, BREADY held low 5 cycles -> single write, BVALID held, WSTRB=0x1 writes only byte 0.
REQ-033 Assert reset during an outstanding read (RREADY low) -> RVALID drops immediately; post-reset read of IER returns 0x0.
